// File: rtl/mult_div_seq.sv
// mult_div_seq: iterative signed multiply (radix-2 Booth) / restoring divide feeding HI/LO.
// One iteration per cycle; HI/LO are architectural and only change on result, mthi/mtlo or reset.
module mult_div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);
   typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   state_t state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] wk_hi_q, wk_hi_d, wk_lo_q, wk_lo_d, opnd_q, opnd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic ext_q, ext_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
   logic [WIDTH:0] booth_sum, div_shift, div_trial;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [1:0] booth_sel;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         wk_hi_q <= '0;
         wk_lo_q <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
         ext_q   <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         wk_hi_q <= wk_hi_d;
         wk_lo_q <= wk_lo_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
         ext_q   <= ext_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
      end
   end
   always_comb begin
      // upper half is summed one bit wider so min_int multiplicands cannot overflow before the shift
      booth_sel = {wk_lo_q[0], ext_q};
      booth_sum = {wk_hi_q[WIDTH-1], wk_hi_q}
                + (booth_sel == 2'b01 ? {opnd_q[WIDTH-1], opnd_q}
                :  booth_sel == 2'b10 ? -{opnd_q[WIDTH-1], opnd_q} : '0);
      div_shift = {wk_hi_q, wk_lo_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, opnd_q};
      a_mag     = op_a[WIDTH-1] ? -op_a : op_a;
      b_mag     = op_b[WIDTH-1] ? -op_b : op_b;
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      wk_hi_d   = wk_hi_q;
      wk_lo_d   = wk_lo_q;
      opnd_d    = opnd_q;
      cnt_d     = cnt_q;
      ext_d     = ext_q;
      negq_d    = negq_q;
      negr_d    = negr_q;
      dz_d      = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start_mult) begin
               state_d = MULT;
               wk_hi_d = '0;
               wk_lo_d = op_b;
               opnd_d  = op_a;
               ext_d   = 1'b0;
               cnt_d   = '0;
            end else if (start_div && op_b == '0) begin
               dz_d = 1'b1;
            end else if (start_div) begin
               state_d = DIV;
               wk_hi_d = '0;
               wk_lo_d = a_mag;
               opnd_d  = b_mag;
               negq_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
               negr_d  = op_a[WIDTH-1];
               cnt_d   = '0;
            end
         end
         MULT: begin
            wk_hi_d = booth_sum[WIDTH:1];
            wk_lo_d = {booth_sum[0], wk_lo_q[WIDTH-1:1]};
            ext_d   = wk_lo_q[0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
               hi_d    = booth_sum[WIDTH:1];
               lo_d    = {booth_sum[0], wk_lo_q[WIDTH-1:1]};
            end
         end
         DIV: begin
            wk_hi_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            wk_lo_d = {wk_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) state_d = FIX;
         end
         FIX: begin
            state_d = DONE;
            lo_d    = negq_q ? -wk_lo_q : wk_lo_q;
            hi_d    = negr_q ? -wk_hi_q : wk_hi_q;
         end
         default: state_d = IDLE;
      endcase
   end
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;
   assign busy     = state_q == MULT || state_q == DIV || state_q == FIX;
   assign done     = state_q == DONE;
   assign div_zero = dz_q;
endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: scoreboarded random + directed check of mult_div_seq against longint arithmetic.
module tb_mult_div_seq;
   localparam int W = 32;
   localparam logic [W-1:0] MIN = 32'h8000_0000;
   logic clk = 1'b0;
   logic reset, start_mult, start_div, hi_we, lo_we;
   logic [W-1:0] op_a, op_b, wdata, hi_out, lo_out;
   logic busy, done, div_zero;
   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           due;
   } exp_t;
   exp_t sbq[$];
   exp_t e;
   int checks = 0, failures = 0, cyc = 0;
   logic [W-1:0] ref_hi = '0, ref_lo = '0;
   mult_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
      .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .div_zero(div_zero)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      if (!reset && (done || div_zero)) begin
         if (sbq.size() == 0) chk("unexpected_event", 64'({done, div_zero}), 64'd0);
         else begin
            e = sbq.pop_front();
            chk("event_kind", 64'({done, div_zero}), e.dz ? 64'd1 : 64'd2);
            chk("latency", 64'(cyc), 64'(e.due));
            chk("hi", 64'(hi_out), 64'(e.hi));
            chk("lo", 64'(lo_out), 64'(e.lo));
            chk("busy_at_event", 64'(busy), 64'd0);
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, p, q, r;
      exp_t x;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      start_mult = is_mult;
      start_div  = !is_mult;
      op_a = a;
      op_b = b;
      if (is_mult) begin
         p = sa * sb;
         x = '{p[63:32], p[31:0], 1'b0, cyc + W + 1};
      end else if (b == '0) begin
         x = '{ref_hi, ref_lo, 1'b1, cyc + 1};
      end else begin
         q = sa / sb;
         r = sa % sb;
         x = '{r[31:0], q[31:0], 1'b0, cyc + W + 2};
      end
      if (!x.dz) begin
         ref_hi = x.hi;
         ref_lo = x.lo;
      end
      sbq.push_back(x);
      step();
      start_mult = 1'b0;
      start_div  = 1'b0;
      op_a = $urandom;
      op_b = $urandom;
   endtask
   task automatic wait_idle();
      int n;
      for (n = 0; n < 60 && (sbq.size() != 0 || busy); n++) step();
      if (n == 60) begin
         chk("timeout", 64'(sbq.size()), 64'd0);
         sbq.delete();
      end
      step();
   endtask
   task automatic mt(input bit hi, input logic [W-1:0] v);
      hi_we = hi;
      lo_we = !hi;
      wdata = v;
      if (hi) ref_hi = v;
      else ref_lo = v;
      step();
      hi_we = 1'b0;
      lo_we = 1'b0;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      reset = 1'b1;
      {start_mult, start_div, hi_we, lo_we} = '0;
      op_a = '0;
      op_b = '0;
      wdata = '0;
      repeat (3) step();
      chk("rst_hi", 64'(hi_out), 64'd0);
      chk("rst_lo", 64'(lo_out), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dz", 64'(div_zero), 64'd0);
      reset = 1'b0;
      step();
      issue(1'b1, 32'd7, 32'hFFFF_FFFD);
      chk("busy_mult", 64'(busy), 64'd1);
      wait_idle();
      chk("mult_7x-3_hi", 64'(hi_out), 64'hFFFF_FFFF);
      chk("mult_7x-3_lo", 64'(lo_out), 64'hFFFF_FFEB);
      issue(1'b1, MIN, MIN);
      wait_idle();
      chk("mult_min_hi", 64'(hi_out), 64'h4000_0000);
      issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle();
      issue(1'b0, 32'hFFFF_FFF9, 32'd2);
      chk("busy_div", 64'(busy), 64'd1);
      wait_idle();
      chk("div_-7/2_lo", 64'(lo_out), 64'hFFFF_FFFD);
      chk("div_-7/2_hi", 64'(hi_out), 64'hFFFF_FFFF);
      issue(1'b0, 32'd100, 32'd7);
      wait_idle();
      mt(1'b1, 32'h1234);
      issue(1'b0, 32'd5, 32'd0);
      chk("dz_busy", 64'(busy), 64'd0);
      wait_idle();
      chk("dz_hi_kept", 64'(hi_out), 64'h1234);
      issue(1'b0, MIN, 32'hFFFF_FFFF);
      wait_idle();
      chk("ovf_lo", 64'(lo_out), 64'(MIN));
      issue(1'b1, 32'd12345, 32'hFFFF_0000);
      for (int n = 0; n < 40 && !done; n++) step();
      issue(1'b0, 32'hFFFF_FC00, 32'd9);
      wait_idle();
      issue(1'b1, 32'd1000, 32'd3000);
      repeat (4) step();
      start_div = 1'b1;
      op_b = '0;
      hi_we = 1'b1;
      wdata = 32'hDEAD_BEEF;
      step();
      {start_div, hi_we} = '0;
      wait_idle();
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] a, b;
         a = $urandom;
         b = $urandom;
         if ($urandom_range(3) == 0) b = $urandom_range(7) - 3;
         if ($urandom_range(7) == 0) a = MIN;
         if ($urandom_range(5) == 0) mt($urandom_range(1) == 1, $urandom);
         issue($urandom_range(1) == 1, a, b);
         wait_idle();
      end
      issue(1'b1, 32'd77, 32'd99);
      repeat (9) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      sbq.delete();
      ref_hi = '0;
      ref_lo = '0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hi", 64'(hi_out), 64'd0);
      chk("abort_lo", 64'(lo_out), 64'd0);
      repeat (40) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
